// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// TAG_BASE is only referenced when UART_TX_ARB_SOURCE_TAG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    GRANT  = 2'd2
  } arb_state_t;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  // Increment with an explicit wrap at n, so non-power-of-two counts are safe.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker. It returns the first set request at or
// after i_ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_idx;

  // The scan runs from the farthest slot down to i_ptr, so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_found = 1'b1;
        o_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the UART TX port.
// A grant is released on req_last or after MAX_BURST bytes, whichever comes first.
// Optional: define UART_TX_ARB_SOURCE_TAG_EN to prefix every grant with a
// TAG_BASE|grant_id header byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_id;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_busy;

  logic                  w_found;
  logic [IDX_W-1:0]      w_pick;
  logic                  w_xfer;
  logic                  w_release;
  logic [DATA_WIDTH-1:0] w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign grant_id  = r_grant_id;
  assign busy      = r_busy;
  assign w_xfer    = tx_valid && tx_ready && ena;
  assign w_release = (r_state == GRANT) && w_xfer &&
                     (req_last[r_grant_id] || (r_burst_cnt == CNT_W'(MAX_BURST - 1)));

  // TX side: header or pass-through of the granted requester, all gated by ena.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (ena) begin
      case (r_state)
`ifdef UART_TX_ARB_SOURCE_TAG_EN
        HEADER: begin
          tx_valid = 1'b1;
          tx_data  = DATA_WIDTH'(TAG_BASE) | DATA_WIDTH'(r_grant_id);
        end
`endif
        GRANT: begin
          tx_valid              = req_valid[r_grant_id];
          tx_data               = w_bytes[r_grant_id];
          req_ready[r_grant_id] = tx_ready;
        end
        default: ;
      endcase
    end
  end

  // Arbitration FSM. With ena low every register holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE: if (w_found) begin
          r_grant_id  <= w_pick;
          r_busy      <= 1'b1;
          r_burst_cnt <= '0;
`ifdef UART_TX_ARB_SOURCE_TAG_EN
          r_state     <= HEADER;
`else
          r_state     <= GRANT;
`endif
        end
`ifdef UART_TX_ARB_SOURCE_TAG_EN
        HEADER: if (w_xfer) r_state <= GRANT;
`endif
        GRANT: if (w_xfer) begin
          r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          if (w_release) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= IDX_W'(ptr_inc(32'(r_grant_id), 32'(NUM_REQ)));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel (tx_data/tx_valid/tx_ready) between NUM_REQ byte-stream requesters.
- Uses packet-locked round-robin arbitration with a starvation cap of MAX_BURST bytes per grant.
- Sits between on-chip producers (echo path, status reporter, shift-register dump) and the uart instance's TX port inside the top-level wrapper.

Parameters:
- DATA_WIDTH, 8, byte width; must match the uart instance.
- NUM_REQ, 4, number of requesters; must be 2..8.
- MAX_BURST, 16, maximum bytes forwarded per grant before a forced release; must be at least 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- ena  input  1  design enable; when low, state is frozen and no handshakes occur
- req_data  input  NUM_REQ*DATA_WIDTH  requester bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_valid  input  NUM_REQ  per-requester byte valid
- req_last  input  NUM_REQ  marks the final byte of a packet; qualified by req_valid
- req_ready  output  NUM_REQ  per-requester accept
- tx_data  output  DATA_WIDTH  to uart tx_data
- tx_valid  output  1  to uart tx_valid
- tx_ready  input  1  from uart tx_ready
- grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grant
- busy  output  1  high while any requester holds a grant

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0.
  - req_ready=0, tx_valid=0, tx_data=0, busy=0.
- Handshake rule: a byte transfers in a cycle where tx_valid && tx_ready && ena.
- States: IDLE, HEADER (optional feature only), GRANT.
- IDLE:
  - If any req_valid, pick the first set bit searching rr_ptr, rr_ptr+1, … with modulo NUM_REQ wrap.
  - Register the pick into grant_id, set busy=1, clear burst_cnt, move to GRANT (or HEADER with the feature).
  - Arbitration costs exactly one cycle; no byte is forwarded in IDLE.
- GRANT:
  - Combinational pass-through: tx_data = req_data[grant_id], tx_valid = req_valid[grant_id], req_ready[grant_id] = tx_ready.
  - All other req_ready bits are 0.
  - On each transfer, burst_cnt increments.
  - Release when the transfer carries req_last[grant_id], or when burst_cnt == MAX_BURST-1 at transfer time.
  - On release: state=IDLE, busy=0, rr_ptr = (grant_id+1) mod NUM_REQ. grant_id holds its value.
- A requester that drops req_valid mid-packet keeps the grant; the arbiter stalls indefinitely. There is no timeout.
- Simultaneous requests in IDLE: only one is granted. The others remain pending and are served in rotation, so no requester waits more than NUM_REQ-1 grants.
- Release and a new request in the same cycle: the new request is not granted that cycle; the next cycle is IDLE arbitration.
- ena=0: all registers hold, tx_valid=0, req_ready=0. Operation resumes unchanged when ena returns.
- reset_n asserted mid-packet: the packet is abandoned and the arbiter returns to reset values. The partial packet is not resumed.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and grant_id are $clog2(NUM_REQ) bits with an explicit modulo wrap. Do not rely on natural overflow when NUM_REQ is not a power of two.

Optional Feature:
- Macro: UART_TX_ARB_SOURCE_TAG_EN.
- With the macro defined:
  - After arbitration the FSM enters HEADER and drives tx_valid=1, tx_data = TAG_BASE | grant_id, with all req_ready=0.
  - When that byte transfers, the FSM moves to GRANT.
  - The header byte does not count toward burst_cnt.
  - Forced release re-tags the packet on its next grant.
- Without the macro: the HEADER state, TAG_BASE logic, and the extra cycle do not exist, and IDLE goes directly to GRANT.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum arb_state_t {IDLE, HEADER, GRANT};
  - localparam TAG_BASE = 8'hA0;
  - a function for modulo pointer increment.
- Sub-module rr_picker (combinational): inputs req vector and rr_ptr; outputs found flag and picked index. It is parameterised by NUM_REQ and reusable by other arbiters.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with req_valid=4'b1111 → tx_valid=0, req_ready=0, busy=0, grant_id=0 throughout.
- Single requester: req 2 sends 0x41,0x42,0x43 (last on 0x43) with tx_ready=1 → tx_data sequence 41,42,43 starting 1 cycle after req_valid; busy drops the cycle after 0x43; rr_ptr becomes 3.
- Round-robin: all four requesters hold one-byte packets continuously → grant order 0,1,2,3,0 with one idle arbitration cycle between grants.
- Burst cap: MAX_BURST=4; req 0 streams 10 bytes without last while req 1 is pending → req 0 sends 4 bytes, then req 1 is granted, then req 0 resumes with byte 5.
- Backpressure and ena: tx_ready toggles 1,0,0,1 and ena is low for 2 cycles mid-packet → no byte is duplicated or lost, and req_ready matches tx_ready only while ena=1.
- UART_TX_ARB_SOURCE_TAG_EN: req 3 sends 0x55 (last) → tx_data sequence A3, 55; req_ready[3] stays low during the A3 byte.
